dit_arbiter: RTL and testbench

DIT_ARBITER -- requirements
Module: dit_arbiter

---
 rtl/dit_arbiter_pkg.sv | 6 +
 rtl/dit_arb_fsm.sv | 52 +++++
 rtl/dit_arbiter.sv | 123 ++++++++++++
 tb/tb_dit_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dit_arbiter_pkg.sv
// dit_arbiter_pkg: grant FSM state encodings and channel ids shared by the arbiter files
package dit_arbiter_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2} arb_state_e;
    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;
endpackage

// File: rtl/dit_arb_fsm.sv
// dit_arb_fsm: grant FSM with alternating tie-break and per-frame sample counter
module dit_arb_fsm
    import dit_arbiter_pkg::*;
#(
    parameter int N     = 8,
    parameter int NLOG2 = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_req_i,
    input  logic       b_req_i,
    input  logic       a_nd_i,
    input  logic       b_nd_i,
    output arb_state_e state_o
);
    arb_state_e       state_q, state_d;
    logic [NLOG2-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             own_nd, frame_end;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        own_nd    = (state_q == OWN_A && a_nd_i) || (state_q == OWN_B && b_nd_i);
        frame_end = cnt_q == NLOG2'(N - 1);
        if (state_q == IDLE) begin
            // on a tie, A wins only if B was served last
            if (a_req_i && (!b_req_i || last_q == CH_B)) begin
                state_d = OWN_A;
                last_d  = CH_A;
            end else if (b_req_i) begin
                state_d = OWN_B;
                last_d  = CH_B;
            end
        end else if (own_nd) begin
            cnt_d   = frame_end ? '0 : cnt_q + 1'b1;
            state_d = frame_end ? IDLE : state_q;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= CH_B;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end
    assign state_o = state_q;
endmodule

// File: rtl/dit_arbiter.sv
// dit_arbiter: shares one dit FFT between channels A and B, routing results back by tag MSB
module dit_arbiter
    import dit_arbiter_pkg::*;
#(
    parameter int N      = 8,
    parameter int NLOG2  = 3,
    parameter int X_WDTH = 32,
    parameter int M_WDTH = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_req,
    input  logic                b_req,
    output logic                a_gnt,
    output logic                b_gnt,
    input  logic [2*X_WDTH-1:0] a_data,
    input  logic [2*X_WDTH-1:0] b_data,
    input  logic                a_nd,
    input  logic                b_nd,
    input  logic [M_WDTH-2:0]   a_m,
    input  logic [M_WDTH-2:0]   b_m,
    output logic [2*X_WDTH-1:0] fft_in_data,
    output logic                fft_in_nd,
    output logic [M_WDTH-1:0]   fft_in_m,
    input  logic [2*X_WDTH-1:0] fft_out_data,
    input  logic                fft_out_nd,
    input  logic [M_WDTH-1:0]   fft_out_m,
    input  logic                fft_first,
    input  logic                fft_error,
    output logic [2*X_WDTH-1:0] a_out_data,
    output logic [2*X_WDTH-1:0] b_out_data,
    output logic                a_out_nd,
    output logic                b_out_nd,
    output logic [M_WDTH-2:0]   a_out_m,
    output logic [M_WDTH-2:0]   b_out_m,
    output logic                a_first,
    output logic                b_first,
    output logic                error
);
    arb_state_e          state;
    logic                own_a, own_b, sel_nd, to_a, to_b;
    logic                in_nd_q, in_nd_d, error_q, error_d;
    logic [2*X_WDTH-1:0] in_data_q, in_data_d, a_data_q, a_data_d, b_data_q, b_data_d;
    logic [M_WDTH-1:0]   in_m_q, in_m_d;
    logic [M_WDTH-2:0]   a_m_q, a_m_d, b_m_q, b_m_d;
    logic                a_nd_q, a_nd_d, b_nd_q, b_nd_d, a_first_q, a_first_d, b_first_q, b_first_d;

    dit_arb_fsm #(.N(N), .NLOG2(NLOG2)) u_fsm (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_req_i (a_req),
        .b_req_i (b_req),
        .a_nd_i  (a_nd),
        .b_nd_i  (b_nd),
        .state_o (state)
    );

    always_comb begin
        own_a     = state == OWN_A;
        own_b     = state == OWN_B;
        sel_nd    = (own_a && a_nd) || (own_b && b_nd);
        in_nd_d   = sel_nd;
        in_data_d = sel_nd ? (own_a ? a_data : b_data) : in_data_q;
        in_m_d    = sel_nd ? (own_a ? {CH_A, a_m} : {CH_B, b_m}) : in_m_q;
        // results route on the tag alone, whoever holds the grant now
        to_a      = fft_out_nd && fft_out_m[M_WDTH-1] == CH_A;
        to_b      = fft_out_nd && fft_out_m[M_WDTH-1] == CH_B;
        a_nd_d    = to_a;
        b_nd_d    = to_b;
        a_first_d = to_a && fft_first;
        b_first_d = to_b && fft_first;
        a_data_d  = to_a ? fft_out_data : a_data_q;
        b_data_d  = to_b ? fft_out_data : b_data_q;
        a_m_d     = to_a ? fft_out_m[M_WDTH-2:0] : a_m_q;
        b_m_d     = to_b ? fft_out_m[M_WDTH-2:0] : b_m_q;
        error_d   = error_q || fft_error || (a_nd && !own_a) || (b_nd && !own_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_nd_q   <= 1'b0;
            in_data_q <= '0;
            in_m_q    <= '0;
            a_nd_q    <= 1'b0;
            b_nd_q    <= 1'b0;
            a_first_q <= 1'b0;
            b_first_q <= 1'b0;
            a_data_q  <= '0;
            b_data_q  <= '0;
            a_m_q     <= '0;
            b_m_q     <= '0;
            error_q   <= 1'b0;
        end else begin
            in_nd_q   <= in_nd_d;
            in_data_q <= in_data_d;
            in_m_q    <= in_m_d;
            a_nd_q    <= a_nd_d;
            b_nd_q    <= b_nd_d;
            a_first_q <= a_first_d;
            b_first_q <= b_first_d;
            a_data_q  <= a_data_d;
            b_data_q  <= b_data_d;
            a_m_q     <= a_m_d;
            b_m_q     <= b_m_d;
            error_q   <= error_d;
        end
    end

    assign a_gnt       = own_a;
    assign b_gnt       = own_b;
    assign fft_in_nd   = in_nd_q;
    assign fft_in_data = in_data_q;
    assign fft_in_m    = in_m_q;
    assign a_out_nd    = a_nd_q;
    assign b_out_nd    = b_nd_q;
    assign a_first     = a_first_q;
    assign b_first     = b_first_q;
    assign a_out_data  = a_data_q;
    assign b_out_data  = b_data_q;
    assign a_out_m     = a_m_q;
    assign b_out_m     = b_m_q;
    assign error       = error_q;
endmodule

// File: tb/tb_dit_arbiter.sv
// tb_dit_arbiter: directed scenarios plus random traffic against a transaction-level model
module tb_dit_arbiter;
    localparam int N  = 8;
    localparam int XW = 32;
    localparam int MW = 6;
    localparam int AW = 4 + MW + 2*XW + 2*(2 + MW - 1 + 2*XW);

    logic clk = 1'b0, rst_n = 1'b0;
    logic a_req, b_req, a_gnt, b_gnt, a_nd, b_nd, fft_in_nd, fft_out_nd, fft_first, fft_error;
    logic [2*XW-1:0] a_data, b_data, fft_in_data, fft_out_data, a_out_data, b_out_data;
    logic [MW-2:0]   a_m, b_m, a_out_m, b_out_m;
    logic [MW-1:0]   fft_in_m, fft_out_m;
    logic            a_out_nd, b_out_nd, a_first, b_first, error;
    logic [AW-1:0]   all_out;

    int n_vec = 0, n_err = 0;

    // model: owner 0=none 1=A 2=B, samples taken this frame, last channel served
    int              m_own, m_cnt, m_last;
    logic            m_err, m_in_nd, m_a_nd, m_b_nd, m_a_first, m_b_first;
    logic [2*XW-1:0] m_in_data, m_a_data, m_b_data;
    logic [MW-1:0]   m_in_m;
    logic [MW-2:0]   m_a_m, m_b_m;

    dit_arbiter #(.N(N), .NLOG2(3), .X_WDTH(XW), .M_WDTH(MW)) dut (
        .clk(clk), .rst_n(rst_n), .a_req(a_req), .b_req(b_req), .a_gnt(a_gnt), .b_gnt(b_gnt),
        .a_data(a_data), .b_data(b_data), .a_nd(a_nd), .b_nd(b_nd), .a_m(a_m), .b_m(b_m),
        .fft_in_data(fft_in_data), .fft_in_nd(fft_in_nd), .fft_in_m(fft_in_m),
        .fft_out_data(fft_out_data), .fft_out_nd(fft_out_nd), .fft_out_m(fft_out_m),
        .fft_first(fft_first), .fft_error(fft_error),
        .a_out_data(a_out_data), .b_out_data(b_out_data), .a_out_nd(a_out_nd), .b_out_nd(b_out_nd),
        .a_out_m(a_out_m), .b_out_m(b_out_m), .a_first(a_first), .b_first(b_first), .error(error)
    );

    always #5 clk = ~clk;

    assign all_out = {a_gnt, b_gnt, error, fft_in_nd, fft_in_m, fft_in_data,
                      a_out_nd, a_first, a_out_m, a_out_data, b_out_nd, b_first, b_out_m, b_out_data};

    function automatic logic [AW-1:0] exp_all();
        return {m_own == 1, m_own == 2, m_err, m_in_nd, m_in_m, m_in_data,
                m_a_nd, m_a_first, m_a_m, m_a_data, m_b_nd, m_b_first, m_b_m, m_b_data};
    endfunction

    task automatic model_reset();
        m_own = 0; m_cnt = 0; m_last = 2; m_err = 1'b0;
        m_in_nd = 1'b0; m_in_data = '0; m_in_m = '0;
        m_a_nd = 1'b0; m_b_nd = 1'b0; m_a_first = 1'b0; m_b_first = 1'b0;
        m_a_data = '0; m_b_data = '0; m_a_m = '0; m_b_m = '0;
    endtask

    task automatic clr_in();
        a_req = 0; b_req = 0; a_nd = 0; b_nd = 0; a_data = '0; b_data = '0; a_m = '0; b_m = '0;
        fft_out_nd = 0; fft_out_m = '0; fft_out_data = '0; fft_first = 0; fft_error = 0;
    endtask

    task automatic step();
        logic nd;
        @(posedge clk);
        nd = (m_own == 1) ? a_nd : (m_own == 2) ? b_nd : 1'b0;
        if ((a_nd && m_own != 1) || (b_nd && m_own != 2) || fft_error) m_err = 1'b1;
        m_in_nd = nd;
        if (nd) begin
            m_in_data = (m_own == 1) ? a_data : b_data;
            m_in_m    = (m_own == 1) ? {1'b0, a_m} : {1'b1, b_m};
        end
        if (m_own == 0) begin
            if (a_req && b_req) m_own = (m_last == 1) ? 2 : 1;
            else if (a_req)     m_own = 1;
            else if (b_req)     m_own = 2;
            if (m_own != 0) m_last = m_own;
        end else if (nd) begin
            m_cnt++;
            if (m_cnt == N) begin m_cnt = 0; m_own = 0; end
        end
        m_a_nd = fft_out_nd && !fft_out_m[MW-1];
        m_b_nd = fft_out_nd && fft_out_m[MW-1];
        m_a_first = m_a_nd && fft_first;
        m_b_first = m_b_nd && fft_first;
        if (m_a_nd) begin m_a_data = fft_out_data; m_a_m = fft_out_m[MW-2:0]; end
        if (m_b_nd) begin m_b_data = fft_out_data; m_b_m = fft_out_m[MW-2:0]; end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        model_reset();
        rst_n = 1;
    endtask

    task automatic test_reset();
        clr_in();
        model_reset();
        #1;
        n_vec++;
        if (all_out !== '0) begin n_err++; $display("FAIL reset_all got=%h exp=0", all_out); end
        #10 rst_n = 1;
        step();
        n_vec++;
        if (all_out !== exp_all()) begin n_err++; $display("FAIL reset_idle got=%h exp=%h", all_out, exp_all()); end
    endtask

    task automatic test_single_a();
        logic [2*XW-1:0] d;
        a_req = 1;
        step();
        n_vec++;
        if (a_gnt !== 1'b1) begin n_err++; $display("FAIL single_gnt got=%b exp=1", a_gnt); end
        a_req = 0;
        for (int i = 0; i < N; i++) begin
            d = {$urandom, $urandom};
            a_nd = 1; a_m = 5'd5; a_data = d;
            step();
            n_vec++;
            if ({fft_in_nd, fft_in_m, fft_in_data} !== {1'b1, 6'h05, d}) begin
                n_err++; $display("FAIL single_in i=%0d got=%b/%h/%h exp=1/05/%h", i, fft_in_nd, fft_in_m, fft_in_data, d);
            end
            n_vec++;
            if (a_gnt !== (i < N - 1)) begin n_err++; $display("FAIL single_hold i=%0d got=%b exp=%b", i, a_gnt, i < N - 1); end
        end
        a_nd = 0;
        step();
        n_vec++;
        if ({fft_in_nd, fft_in_m, error, a_gnt} !== {1'b0, 6'h05, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL single_after got=%b/%h/%b/%b exp=0/05/0/0", fft_in_nd, fft_in_m, error, a_gnt);
        end
    endtask

    task automatic test_arb();
        do_reset();
        a_req = 1; b_req = 1;
        step();
        n_vec++;
        if ({a_gnt, b_gnt} !== 2'b10) begin n_err++; $display("FAIL arb_first got=%b%b exp=10", a_gnt, b_gnt); end
        for (int i = 0; i < N; i++) begin a_nd = 1; a_data = {$urandom, $urandom}; step(); end
        a_nd = 0;
        n_vec++;
        if ({a_gnt, b_gnt} !== 2'b00) begin n_err++; $display("FAIL arb_gap got=%b%b exp=00", a_gnt, b_gnt); end
        step();
        n_vec++;
        if ({a_gnt, b_gnt} !== 2'b01) begin n_err++; $display("FAIL arb_second got=%b%b exp=01", a_gnt, b_gnt); end
        for (int i = 0; i < N; i++) begin
            b_nd = 1; b_m = 5'd3; b_data = {$urandom, $urandom};
            step();
            n_vec++;
            if (fft_in_m !== 6'h23) begin n_err++; $display("FAIL arb_b_tag i=%0d got=%h exp=23", i, fft_in_m); end
        end
        b_nd = 0; a_req = 0; b_req = 0;
        step();
        n_vec++;
        if (all_out !== exp_all()) begin n_err++; $display("FAIL arb_end got=%h exp=%h", all_out, exp_all()); end
    endtask

    task automatic test_bad_nd();
        a_req = 1;
        step();
        a_req = 0; b_nd = 1;
        step();
        b_nd = 0;
        n_vec++;
        if ({fft_in_nd, error} !== 2'b01) begin n_err++; $display("FAIL bad_nd got=%b%b exp=01", fft_in_nd, error); end
        for (int i = 0; i < N; i++) begin a_nd = 1; step(); end
        a_nd = 0;
        step();
        n_vec++;
        if ({a_gnt, error} !== 2'b01) begin n_err++; $display("FAIL bad_sticky got=%b%b exp=01", a_gnt, error); end
        rst_n = 0;
        #1;
        n_vec++;
        if (error !== 1'b0) begin n_err++; $display("FAIL bad_clear got=%b exp=0", error); end
        model_reset();
        rst_n = 1;
        a_nd = 1;
        step();
        a_nd = 0;
        n_vec++;
        if ({fft_in_nd, error} !== 2'b01) begin n_err++; $display("FAIL idle_nd got=%b%b exp=01", fft_in_nd, error); end
        do_reset();
    endtask

    task automatic test_route();
        logic [2*XW-1:0] d1, d2;
        d1 = {$urandom, $urandom};
        d2 = {$urandom, $urandom};
        fft_out_nd = 1; fft_out_m = 6'h23; fft_first = 1; fft_out_data = d1;
        step();
        n_vec++;
        if ({b_out_nd, b_out_m, b_first, b_out_data, a_out_nd, a_first} !== {1'b1, 5'd3, 1'b1, d1, 2'b00}) begin
            n_err++; $display("FAIL route_b got=%b/%h/%b/%h a=%b%b exp=1/03/1/%h a=00", b_out_nd, b_out_m, b_first, b_out_data, a_out_nd, a_first, d1);
        end
        fft_out_m = 6'h05; fft_first = 0; fft_out_data = d2;
        step();
        n_vec++;
        if ({a_out_nd, a_out_m, a_first, a_out_data, b_out_nd, b_out_data} !== {1'b1, 5'd5, 1'b0, d2, 1'b0, d1}) begin
            n_err++; $display("FAIL route_a got=%b/%h/%b/%h b=%b/%h exp=1/05/0/%h b=0/%h", a_out_nd, a_out_m, a_first, a_out_data, b_out_nd, b_out_data, d2, d1);
        end
        fft_out_nd = 0;
        step();
        n_vec++;
        if ({a_out_nd, b_out_nd, a_first, b_first} !== 4'b0000) begin
            n_err++; $display("FAIL route_idle got=%b%b%b%b exp=0000", a_out_nd, b_out_nd, a_first, b_first);
        end
    endtask

    task automatic test_drop_req();
        a_req = 1;
        step();
        for (int i = 0; i < N; i++) begin
            if (i == 3) a_req = 0;
            a_nd = 0;
            if (i >= 3) step();
            n_vec++;
            if (a_gnt !== 1'b1) begin n_err++; $display("FAIL drop_hold i=%0d got=%b exp=1", i, a_gnt); end
            a_nd = 1;
            step();
        end
        a_nd = 0;
        n_vec++;
        if (a_gnt !== 1'b0) begin n_err++; $display("FAIL drop_release got=%b exp=0", a_gnt); end
        fft_error = 1;
        step();
        fft_error = 0;
        step();
        n_vec++;
        if (error !== 1'b1) begin n_err++; $display("FAIL fft_error got=%b exp=1", error); end
        do_reset();
    endtask

    task automatic test_mid_reset();
        a_req = 1;
        step();
        a_req = 0;
        for (int i = 0; i < 4; i++) begin a_nd = 1; a_data = {$urandom, $urandom}; step(); end
        a_nd = 0;
        fft_out_nd = 1; fft_out_m = 6'h21; fft_first = 1;
        step();
        fft_out_nd = 0; fft_first = 0;
        #2 rst_n = 0;
        #1;
        n_vec++;
        if (all_out !== '0) begin n_err++; $display("FAIL midrst_all got=%h exp=0", all_out); end
        model_reset();
        a_req = 1;
        #1 rst_n = 1;
        step();
        a_req = 0;
        for (int i = 0; i < N; i++) begin
            n_vec++;
            if (a_gnt !== 1'b1) begin n_err++; $display("FAIL midrst_restart i=%0d got=%b exp=1", i, a_gnt); end
            a_nd = 1;
            step();
        end
        a_nd = 0;
        n_vec++;
        if (all_out !== exp_all()) begin n_err++; $display("FAIL midrst_end got=%h exp=%h", all_out, exp_all()); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            a_req = $urandom_range(0, 3) == 0;
            b_req = $urandom_range(0, 3) == 0;
            a_nd = (m_own == 1 && $urandom_range(0, 1) == 1) || $urandom_range(0, 99) == 0;
            b_nd = (m_own == 2 && $urandom_range(0, 1) == 1) || $urandom_range(0, 99) == 0;
            a_data = {$urandom, $urandom}; b_data = {$urandom, $urandom};
            a_m = 5'($urandom); b_m = 5'($urandom);
            fft_out_nd = $urandom_range(0, 1) == 1;
            fft_out_m = 6'($urandom); fft_first = $urandom_range(0, 1) == 1;
            fft_out_data = {$urandom, $urandom};
            fft_error = $urandom_range(0, 299) == 0;
            step();
            n_vec++;
            if (all_out !== exp_all()) begin n_err++; $display("FAIL rnd c=%0d got=%h exp=%h", c, all_out, exp_all()); end
        end
        clr_in();
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_arb();
        test_bad_nd();
        test_route();
        test_drop_req();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
